etapa_memoria: RTL and testbench

MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM buffer and the MEM/WB buffer. Holds the data memory and performs LW/LH/LHU/LB/LBU/SW/SH/SB through a fixed-latency access FSM. Asserts a stall while an access is in flight and forwards the ALU result, destination register and WB control to the MEM/WB buffer.

---
 rtl/etapa_memoria.sv | 179 +++++++++++++++++
 tb/tb_etapa_memoria.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/etapa_memoria.sv
// etapa_memoria: MEM stage of the 5-stage MIPS pipeline.
// Holds the data memory (PALABRAS x 32 bit, little-endian byte lanes) and runs
// LW/LH/LHU/LB/LBU/SW/SH/SB through a fixed-latency access FSM
// (INACTIVO -> ESPERA -> COMPLETO). stall_MEM is high for LATENCIA+1 cycles
// per aligned access; the result appears in the COMPLETO cycle.
// Ports:
//   clk, reset (async, active low)
//   mem_leer, mem_escribir, tamano, con_signo : access request from EX/MEM
//   resultado_alu, dato_escribir             : byte address / store data
//   registro_destino, reg_escribir, mem_a_reg : WB control from EX/MEM
//   stall_MEM, excepcion_desalineado          : hazard / exception outputs
//   dato_memoria_MEM, resultado_alu_MEM,
//   registro_destino_MEM, reg_escribir_MEM,
//   mem_a_reg_MEM                             : to MEM/WB buffer
module etapa_memoria #(
  parameter int unsigned PALABRAS = 256,
  parameter int unsigned LATENCIA = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_leer,
  input  logic        mem_escribir,
  input  logic [1:0]  tamano,
  input  logic        con_signo,
  input  logic [31:0] resultado_alu,
  input  logic [31:0] dato_escribir,
  input  logic [4:0]  registro_destino,
  input  logic        reg_escribir,
  input  logic        mem_a_reg,
  output logic        stall_MEM,
  output logic        excepcion_desalineado,
  output logic [31:0] dato_memoria_MEM,
  output logic [31:0] resultado_alu_MEM,
  output logic [4:0]  registro_destino_MEM,
  output logic        reg_escribir_MEM,
  output logic        mem_a_reg_MEM
);

  localparam int unsigned IW = $clog2(PALABRAS);
  localparam int unsigned CW = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;

  typedef enum logic [1:0] {
    INACTIVO,
    ESPERA,
    COMPLETO
  } estado_t;

  estado_t        r_estado;
  estado_t        w_estado_sig;
  logic [CW-1:0]  r_contador;
  logic [CW-1:0]  w_contador_sig;
  logic [31:0]    r_dato_leido;
  logic [31:0]    r_mem [PALABRAS];

  logic           w_acceso;
  logic           w_mal;
  logic           w_desalineado;
  logic           w_stall;
  logic           w_commit;
  logic [IW-1:0]  w_indice;
  logic [1:0]     w_carril;
  logic [31:0]    w_palabra;
  logic [7:0]     w_byte;
  logic [15:0]    w_media;
  logic [31:0]    w_carga;
  logic [3:0]     w_be;
  logic [31:0]    w_dato_st;

  assign w_acceso  = mem_leer | mem_escribir;
  assign w_indice  = resultado_alu[IW+1:2];
  assign w_carril  = resultado_alu[1:0];
  assign w_palabra = r_mem[w_indice];

  // tamano 11 behaves as a word access
  assign w_mal = ((tamano == 2'b01) & resultado_alu[0]) |
                 (tamano[1] & (|resultado_alu[1:0]));
  assign w_desalineado = reset & w_acceso & w_mal;

  // Load formatting
  assign w_byte  = w_palabra[{w_carril, 3'b000} +: 8];
  assign w_media = resultado_alu[1] ? w_palabra[31:16] : w_palabra[15:0];

  always_comb begin
    w_carga = w_palabra;
    case (tamano)
      2'b00:   w_carga = {{24{con_signo & w_byte[7]}}, w_byte};
      2'b01:   w_carga = {{16{con_signo & w_media[15]}}, w_media};
      default: w_carga = w_palabra;
    endcase
  end

  // Store lane enables; data is replicated so each enabled lane sees its slice
  always_comb begin
    w_be      = 4'b1111;
    w_dato_st = dato_escribir;
    case (tamano)
      2'b00: begin
        w_be      = 4'b0001 << w_carril;
        w_dato_st = {4{dato_escribir[7:0]}};
      end
      2'b01: begin
        w_be      = resultado_alu[1] ? 4'b1100 : 4'b0011;
        w_dato_st = {2{dato_escribir[15:0]}};
      end
      default: begin
        w_be      = 4'b1111;
        w_dato_st = dato_escribir;
      end
    endcase
  end

  // FSM next state
  always_comb begin
    w_estado_sig   = r_estado;
    w_contador_sig = r_contador;
    w_stall        = 1'b0;
    w_commit       = 1'b0;
    case (r_estado)
      INACTIVO: begin
        if (w_acceso && !w_mal) begin
          w_stall        = 1'b1;
          w_contador_sig = CW'(LATENCIA - 1);
          w_estado_sig   = ESPERA;
        end
      end
      ESPERA: begin
        w_stall = 1'b1;
        if (r_contador != '0) begin
          w_contador_sig = r_contador - CW'(1);
        end else begin
          w_commit     = 1'b1;
          w_estado_sig = COMPLETO;
        end
      end
      COMPLETO: begin
        // Unconditional return so still-held inputs do not start a new access
        w_estado_sig = INACTIVO;
      end
      default: begin
        w_estado_sig = INACTIVO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado     <= INACTIVO;
      r_contador   <= '0;
      r_dato_leido <= '0;
    end else begin
      r_estado   <= w_estado_sig;
      r_contador <= w_contador_sig;
      if (w_commit) begin
        // A store (including leer+escribir) leaves zero as its result
        r_dato_leido <= mem_escribir ? '0 : w_carga;
      end
    end
  end

  // Array is not reset; an interrupted store never reaches its commit edge
  always_ff @(posedge clk) begin
    if (w_commit && reset && mem_escribir) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[w_indice][8*k +: 8] <= w_dato_st[8*k +: 8];
        end
      end
    end
  end

  assign stall_MEM             = w_stall & reset;
  assign excepcion_desalineado = w_desalineado;
  assign dato_memoria_MEM      = (r_estado == COMPLETO) ? r_dato_leido : '0;
  assign resultado_alu_MEM     = resultado_alu;
  assign registro_destino_MEM  = registro_destino;
  assign reg_escribir_MEM      = reg_escribir & ~w_desalineado;
  assign mem_a_reg_MEM         = mem_a_reg;

endmodule

// File: tb/tb_etapa_memoria.sv
module tb_etapa_memoria;

  localparam int unsigned PAL = 256;
  localparam int unsigned LAT = 2;
  localparam int unsigned NBYTES = PAL * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_leer, mem_escribir;
  logic [1:0]  tamano;
  logic        con_signo;
  logic [31:0] resultado_alu, dato_escribir;
  logic [4:0]  registro_destino;
  logic        reg_escribir, mem_a_reg;
  logic        stall_MEM, excepcion_desalineado;
  logic [31:0] dato_memoria_MEM, resultado_alu_MEM;
  logic [4:0]  registro_destino_MEM;
  logic        reg_escribir_MEM, mem_a_reg_MEM;

  etapa_memoria #(.PALABRAS(PAL), .LATENCIA(LAT)) dut (
    .clk                  (clk),
    .reset                (reset),
    .mem_leer             (mem_leer),
    .mem_escribir         (mem_escribir),
    .tamano               (tamano),
    .con_signo            (con_signo),
    .resultado_alu        (resultado_alu),
    .dato_escribir        (dato_escribir),
    .registro_destino     (registro_destino),
    .reg_escribir         (reg_escribir),
    .mem_a_reg            (mem_a_reg),
    .stall_MEM            (stall_MEM),
    .excepcion_desalineado(excepcion_desalineado),
    .dato_memoria_MEM     (dato_memoria_MEM),
    .resultado_alu_MEM    (resultado_alu_MEM),
    .registro_destino_MEM (registro_destino_MEM),
    .reg_escribir_MEM     (reg_escribir_MEM),
    .mem_a_reg_MEM        (mem_a_reg_MEM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dato;
    logic        exc;
    logic        regw;
    int unsigned nstall;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        m2r;
  } esperado_t;

  esperado_t   sb[$];
  byte unsigned modelo [NBYTES];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          activo = 1'b0;
  bit          hecho = 1'b0;
  int unsigned cnt_stall = 0;

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nombre, act, req, $time);
    end
  endtask

  // Reference: byte-addressed memory, size in bytes, alignment by modulo
  function automatic esperado_t predecir(input bit rd, input bit wr, input int unsigned tam,
                                         input bit sg, input logic [31:0] addr,
                                         input logic [31:0] d, input logic [4:0] rdest,
                                         input bit regw, input bit m2r);
    esperado_t e;
    int unsigned n, base;
    logic [31:0] v;
    bit acc, mal;
    n    = (tam == 0) ? 1 : (tam == 1) ? 2 : 4;
    base = addr % NBYTES;
    acc  = rd | wr;
    mal  = acc && ((addr % n) != 0);
    e.dato   = 32'h0;
    e.exc    = mal;
    e.regw   = regw && !mal;
    e.nstall = (acc && !mal) ? LAT + 1 : 0;
    e.alu    = addr;
    e.rd     = rdest;
    e.m2r    = m2r;
    if (acc && !mal) begin
      if (wr) begin
        for (int unsigned i = 0; i < n; i++) modelo[base + i] = byte'(d >> (8 * i));
      end else begin
        v = 32'h0;
        for (int unsigned i = 0; i < n; i++) v = v | (32'(modelo[base + i]) << (8 * i));
        if (n < 4 && sg && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        e.dato = v;
      end
    end
    return e;
  endfunction

  task automatic idle();
    mem_leer = 0; mem_escribir = 0; tamano = 2'b10; con_signo = 0;
    resultado_alu = 0; dato_escribir = 0; registro_destino = 0;
    reg_escribir = 0; mem_a_reg = 0;
  endtask

  // Called just after a rising edge; returns just after the edge that ends the instruction
  task automatic issue(input bit rd, input bit wr, input int unsigned tam, input bit sg,
                       input logic [31:0] addr, input logic [31:0] d,
                       input logic [4:0] rdest, input bit regw, input bit m2r);
    int unsigned w;
    mem_leer = rd; mem_escribir = wr; tamano = tam[1:0]; con_signo = sg;
    resultado_alu = addr; dato_escribir = d; registro_destino = rdest;
    reg_escribir = regw; mem_a_reg = m2r;
    sb.push_back(predecir(rd, wr, tam, sg, addr, d, rdest, regw, m2r));
    hecho  = 1'b0;
    activo = 1'b1;
    w = 0;
    while (!hecho && w < 20) begin
      @(posedge clk);
      w++;
    end
    if (!hecho) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got no result after %0d cycles expected <= %0d", w, LAT + 2);
      activo = 1'b0;
      sb.delete();
    end
    #1;
  endtask

  // Monitor: stalled cycles are counted, the first unstalled cycle is the result
  always @(negedge clk) begin
    esperado_t e;
    if (activo && reset) begin
      if (stall_MEM) begin
        cnt_stall++;
        chk("dato_durante_stall", dato_memoria_MEM, 32'h0);
        chk("exc_durante_stall", 32'(excepcion_desalineado), 32'h0);
      end else if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard_vacio: got result expected none");
        activo = 1'b0;
        hecho  = 1'b1;
      end else begin
        e = sb.pop_front();
        chk("ciclos_stall", cnt_stall, e.nstall);
        chk("dato_memoria", dato_memoria_MEM, e.dato);
        chk("excepcion", 32'(excepcion_desalineado), 32'(e.exc));
        chk("reg_escribir", 32'(reg_escribir_MEM), 32'(e.regw));
        chk("resultado_alu", resultado_alu_MEM, e.alu);
        chk("registro_destino", 32'(registro_destino_MEM), 32'(e.rd));
        chk("mem_a_reg", 32'(mem_a_reg_MEM), 32'(e.m2r));
        cnt_stall = 0;
        activo = 1'b0;
        hecho  = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    int unsigned tam, n, k;
    for (int unsigned i = 0; i < NBYTES; i++) modelo[i] = 8'h00;

    // Reset held with an aligned load and then a misaligned word present
    reset = 0;
    idle();
    mem_leer = 1; resultado_alu = 32'h10; reg_escribir = 1;
    #7;
    chk("reset_stall", 32'(stall_MEM), 32'h0);
    chk("reset_dato", dato_memoria_MEM, 32'h0);
    chk("reset_alu_passthru", resultado_alu_MEM, 32'h10);
    resultado_alu = 32'h12;
    #4;
    chk("reset_exc", 32'(excepcion_desalineado), 32'h0);
    idle();
    #2 reset = 1;
    @(posedge clk); #1;

    // Directed cases
    issue(0, 1, 2, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0);
    issue(1, 0, 2, 0, 32'h10, 32'h0, 5'd5, 1, 1);
    issue(1, 0, 0, 1, 32'h13, 32'h0, 5'd6, 1, 1);
    issue(1, 0, 0, 0, 32'h13, 32'h0, 5'd7, 1, 1);
    issue(1, 0, 1, 1, 32'h12, 32'h0, 5'd8, 1, 1);
    issue(1, 0, 1, 0, 32'h10, 32'h0, 5'd9, 1, 1);
    issue(0, 1, 0, 0, 32'h11, 32'hAABBCC55, 5'd0, 0, 0);
    issue(0, 1, 1, 0, 32'h12, 32'hFFFF1234, 5'd0, 0, 0);
    issue(1, 0, 2, 0, 32'h10, 32'h0, 5'd10, 1, 1);
    issue(0, 1, 2, 0, 32'h400, 32'hCAFE0001, 5'd0, 0, 0);
    issue(1, 0, 2, 0, 32'h000, 32'h0, 5'd11, 1, 1);
    issue(1, 0, 2, 0, 32'h02, 32'h0, 5'd12, 1, 1);
    issue(0, 1, 1, 0, 32'h01, 32'h0000BEEF, 5'd13, 1, 0);
    issue(1, 0, 2, 0, 32'h00, 32'h0, 5'd14, 1, 1);
    issue(0, 1, 2, 0, 32'h20, 32'h0, 5'd0, 0, 0);

    // Reset during ESPERA of a store: stall drops at once, store is lost
    mem_escribir = 1; tamano = 2'b10; resultado_alu = 32'h20; dato_escribir = 32'h11111111;
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("reset_mid_stall", 32'(stall_MEM), 32'h0);
    chk("reset_mid_dato", dato_memoria_MEM, 32'h0);
    idle();
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    issue(1, 0, 2, 0, 32'h20, 32'h0, 5'd15, 1, 1);
    issue(0, 0, 2, 0, 32'h12345679, 32'h0, 5'd16, 1, 0);

    // Random phase: fill words 0..15, then mixed traffic over them with wrapped addresses
    for (int unsigned i = 0; i < 16; i++) issue(0, 1, 2, 0, 32'(i * 4), $urandom, 5'd0, 0, 0);
    for (int unsigned i = 0; i < 150; i++) begin
      k   = $urandom_range(0, 9);
      tam = $urandom_range(0, 3);
      n   = (tam == 0) ? 1 : (tam == 1) ? 2 : 4;
      a   = ($urandom << 10) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a - (a % n);
      d   = $urandom;
      case (k)
        0, 1, 2, 3: issue(1, 0, tam, 1'($urandom), a, d, 5'($urandom), 1'($urandom), 1'($urandom));
        4, 5, 6:    issue(0, 1, tam, 1'($urandom), a, d, 5'($urandom), 1'($urandom), 1'($urandom));
        7:          issue(1, 1, tam, 1'($urandom), a, d, 5'($urandom), 1'($urandom), 1'($urandom));
        default:    issue(0, 0, tam, 1'($urandom), $urandom, d, 5'($urandom), 1'($urandom), 1'($urandom));
      endcase
    end
    idle();
    @(posedge clk); #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_residuo: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
